// File: rtl/mux_tree_ctrl.sv
// mux_tree_ctrl
// Control path for the pipelined packet-memory read mux tree. Takes one read
// request per cycle, delays each level's 2-bit select so it meets the data
// wavefront at that level, and emits a valid/tag strobe aligned with the
// tree's final result. A credit counter bounds outstanding reads to the
// downstream buffer depth, because the tree itself cannot stall.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   req_valid       request present
//   req_index       source index, digit [2i+1:2i] selects at level i (0 = leaf)
//   req_tag         opaque tag carried with the read
//   req_ready       high while credits remain (registered credits only)
//   sel_bus         per-level 2-bit selects, level i at [2i+1:2i]
//   out_valid       tree result this cycle is a live read
//   out_tag         tag of that read
//   credit_return   one-cycle pulse, downstream freed one slot
//   credits         current credit count
//   err_overflow    sticky, credit returned while already full
module mux_tree_ctrl #(
  parameter int                  N_LEVELS   = 3,
  parameter logic [N_LEVELS-1:0] DELAY_MASK = '1,
  parameter int                  TAG_WIDTH  = 8,
  parameter int                  CREDITS    = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             req_valid,
  input  logic [2*N_LEVELS-1:0]            req_index,
  input  logic [TAG_WIDTH-1:0]             req_tag,
  output logic                             req_ready,
  output logic [2*N_LEVELS-1:0]            sel_bus,
  output logic                             out_valid,
  output logic [TAG_WIDTH-1:0]             out_tag,
  input  logic                             credit_return,
  output logic [$clog2(CREDITS+1)-1:0]     credits,
  output logic                             err_overflow
);

  localparam int CW = $clog2(CREDITS + 1);
  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

  // Number of registered mux levels strictly below level lvl.
  function automatic int unsigned delay_of(int unsigned lvl);
    int unsigned n;
    n = 0;
    for (int unsigned j = 0; j < lvl; j++) begin
      if (DELAY_MASK[j]) n++;
    end
    return n;
  endfunction

  localparam int unsigned L = delay_of(N_LEVELS);

  logic accept;
  logic [TAG_WIDTH-1:0] tag_d;

  logic [CW-1:0] cred_q, cred_d;
  logic          ovf_q, ovf_d;

  assign req_ready = (cred_q != '0);
  assign accept    = req_valid && req_ready;
  assign tag_d     = accept ? req_tag : '0;

  assign credits      = cred_q;
  assign err_overflow = ovf_q;

  // Per-level select: each level keeps only as many stages as it needs.
  for (genvar i = 0; i < N_LEVELS; i++) begin : g_lvl
    localparam int unsigned DI = delay_of(i);
    logic [1:0] dig_d;

    assign dig_d = accept ? req_index[2*i +: 2] : 2'b00;

    if (DI == 0) begin : g_comb
      assign sel_bus[2*i +: 2] = dig_d;
    end else begin : g_reg
      logic [1:0] sh_q [DI];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int unsigned k = 0; k < DI; k++) sh_q[k] <= '0;
        end else begin
          sh_q[0] <= dig_d;
          for (int unsigned k = 1; k < DI; k++) sh_q[k] <= sh_q[k-1];
        end
      end

      assign sel_bus[2*i +: 2] = sh_q[DI-1];
    end
  end

  // Valid/tag strobe travels alongside the data for the full tree latency.
  if (L == 0) begin : g_out_comb
    assign out_valid = accept;
    assign out_tag   = tag_d;
  end else begin : g_out_reg
    logic                 vld_q [L];
    logic [TAG_WIDTH-1:0] tag_q [L];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int unsigned k = 0; k < L; k++) begin
          vld_q[k] <= 1'b0;
          tag_q[k] <= '0;
        end
      end else begin
        vld_q[0] <= accept;
        tag_q[0] <= tag_d;
        for (int unsigned k = 1; k < L; k++) begin
          vld_q[k] <= vld_q[k-1];
          tag_q[k] <= tag_q[k-1];
        end
      end
    end

    assign out_valid = vld_q[L-1];
    assign out_tag   = tag_q[L-1];
  end

  // Accept and return in the same cycle cancel. A return while full is
  // dropped and flagged; an accept cannot happen at zero credits.
  always_comb begin
    cred_d = cred_q;
    ovf_d  = ovf_q;
    if (accept && !credit_return) begin
      cred_d = cred_q - 1'b1;
    end else if (!accept && credit_return) begin
      if (cred_q == CRED_MAX) ovf_d = 1'b1;
      else                    cred_d = cred_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cred_q <= CRED_MAX;
      ovf_q  <= 1'b0;
    end else begin
      cred_q <= cred_d;
      ovf_q  <= ovf_d;
    end
  end

endmodule

// File: tb/tb_mux_tree_ctrl.sv
module tb_mux_tree_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic [5:0] req_index;
  logic [7:0] req_tag;
  logic       credit_return;

  // default DUT (mask 111), zero-latency DUT (mask 000), half DUT (mask 101)
  logic       rdy_d, rdy_z, rdy_h;
  logic [5:0] sel_d, sel_z, sel_h;
  logic       ov_d, ov_z, ov_h;
  logic [7:0] ot_d, ot_z, ot_h;
  logic [2:0] cr_d, cr_z, cr_h;
  logic       err_d, err_z, err_h;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mux_tree_ctrl u_d (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_index(req_index),
    .req_tag(req_tag), .req_ready(rdy_d), .sel_bus(sel_d), .out_valid(ov_d),
    .out_tag(ot_d), .credit_return(credit_return), .credits(cr_d),
    .err_overflow(err_d)
  );

  mux_tree_ctrl #(.DELAY_MASK(3'b000)) u_z (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_index(req_index),
    .req_tag(req_tag), .req_ready(rdy_z), .sel_bus(sel_z), .out_valid(ov_z),
    .out_tag(ot_z), .credit_return(credit_return), .credits(cr_z),
    .err_overflow(err_z)
  );

  mux_tree_ctrl #(.DELAY_MASK(3'b101)) u_h (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_index(req_index),
    .req_tag(req_tag), .req_ready(rdy_h), .sel_bus(sel_h), .out_valid(ov_h),
    .out_tag(ot_h), .credit_return(credit_return), .credits(cr_h),
    .err_overflow(err_h)
  );

  typedef struct {
    logic       v;
    logic [5:0] idx;
    logic [7:0] tag;
    logic       ret;
    logic [5:0] s_d;
    logic       ov_d;
    logic [7:0] ot_d;
    logic [5:0] s_h;
    logic       ov_h;
    logic [7:0] ot_h;
    logic [2:0] cr;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Called at posedge+1; asserts reset across one edge, releases at posedge+1.
  task automatic do_reset();
    req_valid     = 1'b0;
    req_index     = '0;
    req_tag       = '0;
    credit_return = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_acc;
    //            v     idx    tag    ret   s_d    ov_d  ot_d   s_h    ov_h  ot_h   cr
    tbl[0]  = '{1'b1, 6'h27, 8'hA5, 1'b0, 6'h03, 1'b0, 8'h00, 6'h03, 1'b0, 8'h00, 3'd4};
    tbl[1]  = '{1'b0, 6'h00, 8'h00, 1'b0, 6'h04, 1'b0, 8'h00, 6'h24, 1'b0, 8'h00, 3'd3};
    tbl[2]  = '{1'b0, 6'h00, 8'h00, 1'b0, 6'h20, 1'b0, 8'h00, 6'h00, 1'b1, 8'hA5, 3'd3};
    tbl[3]  = '{1'b0, 6'h00, 8'h00, 1'b0, 6'h00, 1'b1, 8'hA5, 6'h00, 1'b0, 8'h00, 3'd3};
    tbl[4]  = '{1'b1, 6'h1B, 8'h11, 1'b0, 6'h03, 1'b0, 8'h00, 6'h03, 1'b0, 8'h00, 3'd3};
    tbl[5]  = '{1'b1, 6'h24, 8'h22, 1'b0, 6'h08, 1'b0, 8'h00, 6'h18, 1'b0, 8'h00, 3'd2};
    tbl[6]  = '{1'b0, 6'h00, 8'h00, 1'b1, 6'h14, 1'b0, 8'h00, 6'h24, 1'b1, 8'h11, 3'd1};
    tbl[7]  = '{1'b1, 6'h3F, 8'h33, 1'b1, 6'h23, 1'b1, 8'h11, 6'h03, 1'b1, 8'h22, 3'd2};
    tbl[8]  = '{1'b0, 6'h00, 8'h00, 1'b0, 6'h0C, 1'b1, 8'h22, 6'h3C, 1'b0, 8'h00, 3'd2};
    tbl[9]  = '{1'b0, 6'h00, 8'h00, 1'b0, 6'h30, 1'b0, 8'h00, 6'h00, 1'b1, 8'h33, 3'd2};
    tbl[10] = '{1'b0, 6'h00, 8'h00, 1'b0, 6'h00, 1'b1, 8'h33, 6'h00, 1'b0, 8'h00, 3'd2};

    // Reset state (checked while rst is still asserted)
    req_valid = 1'b0; req_index = '0; req_tag = '0; credit_return = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sel", 32'(sel_d), 32'h0);
    chk("rst_ov", 32'(ov_d), 32'h0);
    chk("rst_ot", 32'(ot_d), 32'h0);
    chk("rst_cr", 32'(cr_d), 32'h4);
    chk("rst_rdy", 32'(rdy_d), 32'h1);
    chk("rst_err", 32'(err_d), 32'h0);
    rst = 1'b0;

    // Table-driven pipeline and credit vectors, one row per cycle
    for (int c = 0; c < 11; c++) begin
      req_valid     = tbl[c].v;
      req_index     = tbl[c].idx;
      req_tag       = tbl[c].tag;
      credit_return = tbl[c].ret;
      #3;
      chk($sformatf("c%0d_sel_d", c), 32'(sel_d), 32'(tbl[c].s_d));
      chk($sformatf("c%0d_ov_d", c),  32'(ov_d),  32'(tbl[c].ov_d));
      chk($sformatf("c%0d_ot_d", c),  32'(ot_d),  32'(tbl[c].ot_d));
      chk($sformatf("c%0d_sel_h", c), 32'(sel_h), 32'(tbl[c].s_h));
      chk($sformatf("c%0d_ov_h", c),  32'(ov_h),  32'(tbl[c].ov_h));
      chk($sformatf("c%0d_ot_h", c),  32'(ot_h),  32'(tbl[c].ot_h));
      chk($sformatf("c%0d_sel_z", c), 32'(sel_z), 32'(tbl[c].v ? tbl[c].idx : 6'h00));
      chk($sformatf("c%0d_ov_z", c),  32'(ov_z),  32'(tbl[c].v));
      chk($sformatf("c%0d_ot_z", c),  32'(ot_z),  32'(tbl[c].v ? tbl[c].tag : 8'h00));
      chk($sformatf("c%0d_cr", c),    32'(cr_d),  32'(tbl[c].cr));
      chk($sformatf("c%0d_rdy", c),   32'(rdy_d), 32'h1);
      @(posedge clk); #1;
    end
    chk("tbl_err", 32'(err_d), 32'h0);

    // Credit exhaustion: hold req_valid with no returns
    do_reset();
    n_acc = 0;
    req_valid = 1'b1;
    for (int k = 0; k < 7; k++) begin
      req_tag = 8'(k);
      #3;
      if (rdy_d) n_acc++;
      @(posedge clk); #1;
    end
    chk("exh_accepts", 32'(n_acc), 32'd4);
    #3;
    chk("exh_rdy", 32'(rdy_d), 32'h0);
    chk("exh_cr", 32'(cr_d), 32'h0);
    @(posedge clk); #1;
    credit_return = 1'b1;           // return while requesting at zero credits
    #3;
    chk("ret0_cr", 32'(cr_d), 32'h0);
    @(posedge clk); #1;
    credit_return = 1'b0;
    #3;
    chk("ret1_cr", 32'(cr_d), 32'h1);
    chk("ret1_rdy", 32'(rdy_d), 32'h1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    #3;
    chk("ret2_cr", 32'(cr_d), 32'h0);
    chk("ret2_rdy", 32'(rdy_d), 32'h0);

    // Refill to full, then overflow
    @(posedge clk); #1;
    credit_return = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #3;
      @(posedge clk); #1;
    end
    #3;
    chk("full_cr", 32'(cr_d), 32'h4);
    chk("full_err", 32'(err_d), 32'h0);
    @(posedge clk); #1;
    credit_return = 1'b0;
    #3;
    chk("ovf_cr", 32'(cr_d), 32'h4);
    chk("ovf_err", 32'(err_d), 32'h1);
    @(posedge clk); #1;
    #3;
    chk("ovf_sticky", 32'(err_d), 32'h1);

    // Async reset with three reads in flight
    @(posedge clk); #1;
    do_reset();
    chk("rst2_err", 32'(err_d), 32'h0);
    req_valid = 1'b1;
    req_index = 6'h27;
    for (int k = 0; k < 3; k++) begin
      req_tag = 8'hC1 + 8'(k);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    #1;
    chk("fl_ov_pre", 32'(ov_d), 32'h1);
    chk("fl_ot_pre", 32'(ot_d), 32'hC1);
    rst = 1'b1;                     // mid-cycle, away from any edge
    #1;
    chk("fl_ov_now", 32'(ov_d), 32'h0);
    chk("fl_ot_now", 32'(ot_d), 32'h0);
    chk("fl_sel_now", 32'(sel_d), 32'h0);
    chk("fl_ovh_now", 32'(ov_h), 32'h0);
    chk("fl_cr_now", 32'(cr_d), 32'h4);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #3;
      chk($sformatf("post%0d_ov", k), 32'(ov_d), 32'h0);
      chk($sformatf("post%0d_ovh", k), 32'(ov_h), 32'h0);
      chk($sformatf("post%0d_sel", k), 32'(sel_d), 32'h0);
      chk($sformatf("post%0d_cr", k), 32'(cr_d), 32'h4);
      @(posedge clk); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_tree_ctrl.md
# mux_tree_ctrl

Control-path companion to the pipelined packet-memory read multiplexer. Accepts one read request per cycle (source index plus tag) and drives each level's 2-bit select in step with the data wavefront. Emits a valid/tag strobe aligned with the tree's final result. Because the mux tree cannot stall, a credit counter bounds outstanding reads to the downstream buffer depth.

## Interface
- N_LEVELS, 3: number of 4:1 mux levels; the tree selects among 4^N_LEVELS sources.
- DELAY_MASK, all ones (N_LEVELS bits): bit i set means mux level i is registered.
- TAG_WIDTH, 8: width of the request tag carried alongside the read.
- CREDITS, 4: maximum outstanding reads; equals downstream buffer depth.
- clk  in  1  clock for all state.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_index  in  2*N_LEVELS  source index. Bits [2i+1:2i] select at level i; level 0 is the leaf level.
- req_tag  in  TAG_WIDTH  opaque tag.
- req_ready  out  1  high when credits != 0.
- sel_bus  out  2*N_LEVELS  bits [2i+1:2i] drive level i's sel.
- out_valid  out  1  tree result at this cycle is a live read.
- out_tag  out  TAG_WIDTH  tag of that read.
- credit_return  in  1  one-cycle pulse; downstream freed one slot.
- credits  out  clog2(CREDITS+1)  current credit count.
- err_overflow  out  1  sticky; a credit was returned while already at CREDITS.

## Operation
- Accept = req_valid && req_ready. A non-accepted cycle injects a bubble: valid=0, tag=0, and all selects 0.
- L = popcount(DELAY_MASK) is the end-to-end latency.
- D(i) = popcount(DELAY_MASK[i-1:0]) is the level-i select delay; D(0)=0.
- Level-i select:
  - If D(i)=0, it is the combinational index digit, gated by accept (0 when not accepted).
  - Otherwise it comes from a D(i)-deep shift register of that digit.
- Select shift registers hold only the digits needed: level i keeps 2 bits × D(i) stages.
- out_valid/out_tag: L-deep shift register of {accept, accept ? req_tag : 0}. For L=0 they are combinational pass-through of accept/tag.
- Credit counter:
  - Accept only: decrement.
  - credit_return only: increment.
  - Both in the same cycle: unchanged.
- credit_return when credits == CREDITS: counter holds and err_overflow sets. It clears only on rst.
- No accept is possible at credits == 0, so there is no underflow.
- The pipeline never stalls. Every accepted request emerges exactly L cycles later, regardless of credit_return.

## Timing
- Reset (async assert, release synchronous to clk):
  - All select and valid/tag stages = 0.
  - sel_bus = 0, out_valid = 0, out_tag = 0.
  - credits = CREDITS, req_ready = 1 (credits reset to CREDITS > 0), err_overflow = 0.
- Reset mid-flight discards in-flight reads. No out_valid appears for them, and credits return to CREDITS.
- Request accepted at cycle t:
  - Level i sees its select at cycle t + D(i).
  - out_valid = 1 with the matching tag at cycle t + L.
- req_ready is a function of registered credits only, so there is no combinational path from req_valid.
- Throughput: one read per cycle while credits remain. Back-to-back accepts produce back-to-back out_valid.

## Test plan
- Default parameters (L=3): accept index 6'b10_01_11, tag 8'hA5 at cycle 0.
  - Required: sel_bus[1:0]=11 at cycle 0, sel_bus[3:2]=01 at cycle 1, sel_bus[5:4]=10 at cycle 2.
  - Required: out_valid=1 with out_tag=A5 at cycle 3 only.
- DELAY_MASK=3'b000:
  - Required: sel_bus equals req_index and out_valid equals accept in the same cycle.
- DELAY_MASK=3'b101:
  - Required: D = 0, 1, 1 and L = 2.
  - Indices 0x1B then 0x24 on consecutive cycles produce correctly interleaved selects and two consecutive out_valid pulses at cycles 2 and 3.
- Credit exhaustion (CREDITS=4): hold req_valid high with no returns.
  - Required: exactly 4 accepts, after which req_ready=0 and credits=0.
  - Then pulse credit_return together with req_valid: credits go 0→1, and the next cycle accepts with credits 1→0.
- Simultaneous and overflow cases:
  - Accept and credit_return in the same cycle at credits=2: credits stay 2.
  - credit_return at credits=4: credits stay 4, err_overflow=1 and stays set.
- Assert rst asynchronously with 3 reads in flight:
  - Required: outputs zero immediately, no later out_valid, credits=4 after release.
